// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit slice sequencer: FSM state encoding,
// slice nibble width and the slice function-select codes used by callers.
package alu4_pkg;

    localparam int ALU_NIB_W = 4;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu4_state_e;

    // Slice function selects (interpretation depends on the mode bit).
    localparam logic [3:0] S_ADD = 4'h9;   // arithmetic: A plus B plus carry
    localparam logic [3:0] S_XOR = 4'h6;   // logic: A xor B

endpackage

// File: rtl/alu4_nib_sreg.sv
// Operand/result register for the sequencer: holds the latched W-bit
// operands, presents nibble idx of each to the slice while running, and
// writes the slice result back into nibble idx of the result register.
module alu4_nib_sreg
    import alu4_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int W       = ALU_NIB_W * NIBBLES,
    parameter int IDX_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [W-1:0]         a_in,
    input  logic [W-1:0]         b_in,
    input  logic [IDX_W-1:0]     idx,
    input  logic                 run,
    input  logic [ALU_NIB_W-1:0] y_nib,
    output logic [ALU_NIB_W-1:0] nib_a,
    output logic [ALU_NIB_W-1:0] nib_b,
    output logic [W-1:0]         y,
    output logic [W-1:0]         y_next
);

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] y_q;

    // Nibble select toward the slice (zero outside RUN) and result merge.
    always_comb begin
        nib_a  = '0;
        nib_b  = '0;
        y_next = y_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (run && (idx == IDX_W'(i))) begin
                nib_a = a_q[i*ALU_NIB_W +: ALU_NIB_W];
                nib_b = b_q[i*ALU_NIB_W +: ALU_NIB_W];
                y_next[i*ALU_NIB_W +: ALU_NIB_W] = y_nib;
            end
        end
    end

    // Operands latch on accept; result register tracks the merged value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            y_q <= '0;
        end else begin
            if (load) begin
                a_q <= a_in;
                b_q <= b_in;
            end
            y_q <= y_next;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/alu4_seq_ctrl.sv
// Multi-cycle sequencer driving one external combinational 4-bit ALU slice,
// LSB nibble first, rippling the active-low carry between nibbles.
// Optional feature macro: ALU4_SEQ_FLAGS_EN adds rsp_zero / rsp_sign.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised by the producer, holds its payload
// stable until that edge.
module alu4_seq_ctrl
    import alu4_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [4*NIBBLES-1:0]      req_a,
    input  logic [4*NIBBLES-1:0]      req_b,
    input  logic [3:0]                req_s,
    input  logic                      req_m,
    input  logic                      req_cin,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [4*NIBBLES-1:0]      rsp_y,
    output logic                      rsp_cout,
`ifdef ALU4_SEQ_FLAGS_EN
    output logic                      rsp_zero,
    output logic                      rsp_sign,
`endif
    output logic [3:0]                alu_a,
    output logic [3:0]                alu_b,
    output logic [3:0]                alu_s,
    output logic                      alu_m,
    output logic                      alu_cin_n,
    input  logic [3:0]                alu_y,
    input  logic                      alu_cout_n,
    output logic [1:0]                state_dbg
);

    localparam int W     = ALU_NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    alu4_state_e      state;
    logic [IDX_W-1:0] idx;
    logic             carry_n;
    logic             accept;
    logic             last_nib;
    logic             run;
    logic [W-1:0]     y_next;

    assign accept   = req_valid && req_ready;
    assign run      = (state == ST_RUN);
    assign last_nib = (idx == IDX_W'(NIBBLES - 1));

    // Logic mode never presents a carry to the slice.
    assign alu_cin_n = (run && !alu_m) ? carry_n : 1'b1;
    assign state_dbg = state;

    alu4_nib_sreg #(
        .NIBBLES (NIBBLES),
        .W       (W),
        .IDX_W   (IDX_W)
    ) u_sreg (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .a_in   (req_a),
        .b_in   (req_b),
        .idx    (idx),
        .run    (run),
        .y_nib  (alu_y),
        .nib_a  (alu_a),
        .nib_b  (alu_b),
        .y      (rsp_y),
        .y_next (y_next)
    );

    // Sequencer FSM with its registered handshake, carry and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry_n   <= 1'b1;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_cout  <= 1'b0;
            alu_s     <= 4'h0;
            alu_m     <= 1'b0;
`ifdef ALU4_SEQ_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_sign  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_s     <= req_s;
                        alu_m     <= req_m;
                        carry_n   <= ~req_cin;
                        idx       <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Slice carry-out is undefined in logic mode; keep ours.
                    if (!alu_m) begin
                        carry_n <= alu_cout_n;
                    end
                    if (last_nib) begin
                        idx       <= '0;
                        rsp_valid <= 1'b1;
                        rsp_cout  <= ~alu_m & ~alu_cout_n;
`ifdef ALU4_SEQ_FLAGS_EN
                        rsp_zero  <= (y_next == '0);
                        rsp_sign  <= y_next[W-1];
`endif
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Directed bench for alu4_seq_ctrl (NIBBLES=4) with a behavioural 4-bit
// slice (active-high data, active-low carry) on the alu_* ports.
module tb_alu4_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 16;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [3:0]   req_s;
    logic         req_m;
    logic         req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_y;
    logic         rsp_cout;
`ifdef ALU4_SEQ_FLAGS_EN
    logic         rsp_zero;
    logic         rsp_sign;
`endif
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cin_n;
    logic [3:0]   alu_y;
    logic         alu_cout_n;
    logic [1:0]   state_dbg;

    int checks;
    int failures;

    alu4_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_s      (req_s),
        .req_m      (req_m),
        .req_cin    (req_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_y      (rsp_y),
        .rsp_cout   (rsp_cout),
`ifdef ALU4_SEQ_FLAGS_EN
        .rsp_zero   (rsp_zero),
        .rsp_sign   (rsp_sign),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_cin_n  (alu_cin_n),
        .alu_y      (alu_y),
        .alu_cout_n (alu_cout_n),
        .state_dbg  (state_dbg)
    );

    // Behavioural slice: arithmetic ADD, logic XOR, pass-A otherwise.
    always_comb begin
        logic [4:0] sum;
        sum        = 5'd0;
        alu_y      = alu_a;
        alu_cout_n = 1'b1;
        if (alu_m) begin
            if (alu_s == 4'h6) alu_y = alu_a ^ alu_b;
            alu_cout_n = 1'bx;
        end else if (alu_s == 4'h9) begin
            sum        = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, ~alu_cin_n};
            alu_y      = sum[3:0];
            alu_cout_n = ~sum[4];
        end
    end

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Offer one request and return #1 after its accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                        input logic m, input logic cin);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("send_ready", 32'(req_ready), 32'd1);
        req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Scramble the request bus; only latched copies may matter.
        req_a   = W'($urandom_range(0, 65535));
        req_b   = W'($urandom_range(0, 65535));
        req_s   = 4'($urandom_range(0, 15));
        req_m   = ~m;
        req_cin = ~cin;
    endtask

    // Wait for rsp_valid, optionally checking alu_cin_n stays high in RUN.
    task automatic wait_rsp(input string tag, input bit cin_hi);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            check_eq("req_ready_busy", 32'(req_ready), 32'd0);
            if (cin_hi) check_eq("cin_n_logic", 32'(alu_cin_n), 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd4);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("hs_valid_low", 32'(rsp_valid), 32'd0);
        check_eq("hs_ready_high", 32'(req_ready), 32'd1);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_cin = 1'b0;
        #2;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_y", 32'(rsp_y), 32'h0);
        check_eq("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        check_eq("rst_alu_ab", {24'd0, alu_a, alu_b}, 32'h0);
        check_eq("rst_alu_sm", {27'd0, alu_s, alu_m}, 32'h0);
        check_eq("rst_cin_n", 32'(alu_cin_n), 32'd1);
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: 0x1234 + 0x0FFF = 0x2233, no carry.
        send(16'h1234, 16'h0FFF, 4'h9, 1'b0, 1'b0);
        check_eq("t1_nib0_a", 32'(alu_a), 32'h4);
        check_eq("t1_nib0_b", 32'(alu_b), 32'hF);
        wait_rsp("t1", 1'b0);
        check_eq("t1_y", 32'(rsp_y), 32'h2233);
        check_eq("t1_cout", 32'(rsp_cout), 32'd0);
`ifdef ALU4_SEQ_FLAGS_EN
        check_eq("t1_zero", 32'(rsp_zero), 32'd0);
        check_eq("t1_sign", 32'(rsp_sign), 32'd0);
`endif
        take_rsp();

        // Test 2: 0xFFFF + 1 wraps to zero with carry out.
        send(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0);
        wait_rsp("t2", 1'b0);
        check_eq("t2_y", 32'(rsp_y), 32'h0000);
        check_eq("t2_cout", 32'(rsp_cout), 32'd1);
`ifdef ALU4_SEQ_FLAGS_EN
        check_eq("t2_zero", 32'(rsp_zero), 32'd1);
`endif
        take_rsp();

        // Test 3: logic XOR, carry-in ignored, cin_n high throughout.
        send(16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b1);
        wait_rsp("t3", 1'b1);
        check_eq("t3_y", 32'(rsp_y), 32'h0FF0);
        check_eq("t3_cout", 32'(rsp_cout), 32'd0);
        check_eq("t3_done_cin_n", 32'(alu_cin_n), 32'd1);
        check_eq("t3_done_alu_a", 32'(alu_a), 32'h0);
        check_eq("t3_hold_s", 32'(alu_s), 32'h6);
        check_eq("t3_hold_m", 32'(alu_m), 32'd1);
        take_rsp();

        // Test 4: response back-pressure holds the result.
        send(16'h1234, 16'h0FFF, 4'h9, 1'b0, 1'b0);
        wait_rsp("t4", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("t4_hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("t4_hold_y", 32'(rsp_y), 32'h2233);
            check_eq("t4_hold_cout", 32'(rsp_cout), 32'd0);
            check_eq("t4_hold_ready", 32'(req_ready), 32'd0);
        end
        take_rsp();

        // Test 5: async reset two cycles into RUN aborts the operation.
        send(16'h0010, 16'h0020, 4'h9, 1'b0, 1'b1);
        check_eq("t5_run_cin_n", 32'(alu_cin_n), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("t5_rst_ready", 32'(req_ready), 32'd1);
        check_eq("t5_rst_cin_n", 32'(alu_cin_n), 32'd1);
        check_eq("t5_rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(16'h0001, 16'h0001, 4'h9, 1'b0, 1'b0);
        wait_rsp("t5", 1'b0);
        check_eq("t5_y", 32'(rsp_y), 32'h0002);
        take_rsp();

        // Test 6: req_valid held high; second accept only after handshake.
        req_a = 16'h0003; req_b = 16'h0004; req_s = 4'h9; req_m = 1'b0; req_cin = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_acc1_state", 32'(state_dbg), 32'd1);
        wait_rsp("t6a", 1'b0);
        check_eq("t6a_y", 32'(rsp_y), 32'h0007);
        @(posedge clk); #1;
        check_eq("t6_no_accept_done", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("t6_hs_ready", 32'(req_ready), 32'd1);
        check_eq("t6_hs_state", 32'(state_dbg), 32'd0);
        req_a = 16'h0005; req_b = 16'h0006;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("t6_acc2_ready", 32'(req_ready), 32'd0);
        wait_rsp("t6b", 1'b0);
        check_eq("t6b_y", 32'(rsp_y), 32'h000B);
        take_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
